// File: rtl/gate_truth_table_checker_pkg.sv
// Shared types and constants for the gate truth-table checker.
// Holds FSM state encoding, common truth tables and a width helper.
package gate_truth_table_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_XOR2  = 4'b0110;

    // Bits needed to hold 0..n, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gate_truth_table_checker_settle_timer.sv
// Down-counter with load, decrement and zero flag used to time settling.
// Ports: clk, rst, i_load, i_load_val, i_dec, o_zero.
module settle_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sweeps every input vector of an N-input gate and compares its output
// against the EXPECT truth table.
// Ports: clk, rst, start -> dut_in, dut_out <- gate; busy, done, pass,
// err_count, fail_vec report the last sweep.
module gate_truth_table_checker
    import gate_truth_table_checker_pkg::*;
#(
    parameter int                  N_IN          = 2,
    parameter int                  SETTLE_CYCLES = 1,
    parameter logic [2**N_IN-1:0]  EXPECT        = 4'b0111
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [2**N_IN-1:0]   fail_vec
);

    localparam int            CW      = cnt_width(SETTLE_CYCLES);
    localparam logic [CW-1:0] LP_LOAD = CW'(SETTLE_CYCLES);
    localparam logic [N_IN:0] LP_LAST = (N_IN + 1)'(2**N_IN - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N_IN:0]        r_idx;
    logic [N_IN:0]        w_idx_nxt;
    logic [N_IN-1:0]      r_dut_in;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [N_IN:0]        r_err;
    logic [2**N_IN-1:0]   r_fail;
    logic                 w_zero;
    logic                 w_accept;
    logic                 w_sample;
    logic                 w_last;
    logic                 w_miss;

    assign w_idx_nxt = r_idx + 1'b1;
    assign w_last    = (r_idx == LP_LAST);
    // X/Z on the gate output must read as a mismatch.
    assign w_miss    = (dut_out !== EXPECT[r_idx[N_IN-1:0]]);

    settle_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept || (w_sample && !w_last)),
        .i_load_val (LP_LOAD),
        .i_dec      ((r_state == ST_SETTLE) && !w_zero),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_zero) begin
                    w_sample = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_dut_in <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_fail   <= '0;
        end else begin
            r_done <= w_sample && w_last;
            if (w_accept) begin
                r_idx    <= '0;
                r_dut_in <= '0;
                r_err    <= '0;
                r_fail   <= '0;
                r_pass   <= 1'b0;
                r_busy   <= 1'b1;
            end
            if (w_sample) begin
                if (w_miss) begin
                    r_err                     <= r_err + 1'b1;
                    r_fail[r_idx[N_IN-1:0]]   <= 1'b1;
                end
                if (w_last) begin
                    r_busy   <= 1'b0;
                    r_pass   <= (r_err == '0) && !w_miss;
                    r_dut_in <= '0;
                end else begin
                    r_idx    <= w_idx_nxt;
                    r_dut_in <= w_idx_nxt[N_IN-1:0];
                end
            end
        end
    end

    assign dut_in    = r_dut_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed testbench for gate_truth_table_checker.
// Four checker instances cover default, wrong-table and settle variants.
module tb_gate_truth_table_checker;
    import gate_truth_table_checker_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tie1 = 1'b0;
    logic [3:0] st = 4'b0000;
    wire  [3:0] dn;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic [1:0] in0, in1, in2, in3;
    logic       bz0, bz1, bz2, bz3;
    logic       ps0, ps1, ps2, ps3;
    logic [2:0] ec0, ec1, ec2, ec3;
    logic [3:0] fv0, fv1, fv2, fv3;
    logic       o0, o1, o2, o3;

    assign o0 = tie1 ? 1'b1 : ~&in0;
    assign o1 = ~&in1;
    assign o2 = ~&in2;
    assign o3 = ~&in3;

    gate_truth_table_checker u0 (
        .clk(clk), .rst(rst), .start(st[0]), .dut_in(in0), .dut_out(o0),
        .busy(bz0), .done(dn[0]), .pass(ps0), .err_count(ec0), .fail_vec(fv0));

    gate_truth_table_checker #(.EXPECT(TT_AND2)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .dut_in(in1), .dut_out(o1),
        .busy(bz1), .done(dn[1]), .pass(ps1), .err_count(ec1), .fail_vec(fv1));

    gate_truth_table_checker #(.SETTLE_CYCLES(0)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .dut_in(in2), .dut_out(o2),
        .busy(bz2), .done(dn[2]), .pass(ps2), .err_count(ec2), .fail_vec(fv2));

    gate_truth_table_checker #(.SETTLE_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .start(st[3]), .dut_in(in3), .dut_out(o3),
        .busy(bz3), .done(dn[3]), .pass(ps3), .err_count(ec3), .fail_vec(fv3));

    // Pulses start on instance w for one edge (edge 0), then counts
    // edges until done; reports first done edge and number of pulses.
    task automatic sweep(input int w, input int lim,
                         output int dcyc, output int nd);
        @(posedge clk); #1 st[w] = 1'b1;
        @(posedge clk); #1 st[w] = 1'b0;
        dcyc = -1;
        nd = 0;
        for (int k = 1; k <= lim; k++) begin
            @(posedge clk); #1;
            if (dn[w]) begin
                nd++;
                if (dcyc < 0) dcyc = k;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in0, bz0, dn[0], ps0, ec0, fv0} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {in0, bz0, dn[0], ps0, ec0, fv0});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bz0, dn[0], bz1, bz2, bz3} !== 5'd0) begin
            errors++;
            $display("FAIL reset_idle got %b want 00000",
                     {bz0, dn[0], bz1, bz2, bz3});
        end
    endtask

    task automatic test_nand_pass();
        int dc, nd;
        sweep(0, 12, dc, nd);
        checks++;
        if (dc !== 8) begin
            errors++;
            $display("FAIL nand_done_cycle got %0d want 8", dc);
        end
        checks++;
        if (nd !== 1) begin
            errors++;
            $display("FAIL nand_done_count got %0d want 1", nd);
        end
        checks++;
        if ({ps0, ec0, fv0} !== {1'b1, 3'd0, 4'b0000}) begin
            errors++;
            $display("FAIL nand_results got p=%b e=%0d f=%b want p=1 e=0 f=0000",
                     ps0, ec0, fv0);
        end
    endtask

    task automatic test_tied_high();
        logic [1:0] exp_in;
        tie1 = 1'b1;
        @(posedge clk); #1 st[0] = 1'b1;
        @(posedge clk); #1 st[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            exp_in = 2'(k / 2);
            checks++;
            if (in0 !== exp_in || bz0 !== 1'b1) begin
                errors++;
                $display("FAIL tied_dut_in edge %0d got in=%0d busy=%b want in=%0d busy=1",
                         k, in0, bz0, exp_in);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (dn[0] !== 1'b1 || bz0 !== 1'b0 || in0 !== 2'd0) begin
            errors++;
            $display("FAIL tied_done got done=%b busy=%b in=%0d want 1 0 0",
                     dn[0], bz0, in0);
        end
        checks++;
        if ({ps0, ec0, fv0} !== {1'b0, 3'd1, 4'b1000}) begin
            errors++;
            $display("FAIL tied_results got p=%b e=%0d f=%b want p=0 e=1 f=1000",
                     ps0, ec0, fv0);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ps0, ec0, fv0} !== {1'b0, 3'd1, 4'b1000} || dn[0] !== 1'b0) begin
            errors++;
            $display("FAIL tied_hold got p=%b e=%0d f=%b d=%b want 0 1 1000 0",
                     ps0, ec0, fv0, dn[0]);
        end
        tie1 = 1'b0;
    endtask

    task automatic test_wrong_expect();
        int dc, nd;
        sweep(1, 12, dc, nd);
        checks++;
        if (dc !== 8 || nd !== 1) begin
            errors++;
            $display("FAIL and_done got cyc=%0d n=%0d want 8 1", dc, nd);
        end
        checks++;
        if ({ps1, ec1, fv1} !== {1'b0, 3'd4, 4'b1111}) begin
            errors++;
            $display("FAIL and_results got p=%b e=%0d f=%b want p=0 e=4 f=1111",
                     ps1, ec1, fv1);
        end
    endtask

    task automatic test_settle_variants();
        int dc, nd;
        sweep(2, 8, dc, nd);
        checks++;
        if (dc !== 4 || nd !== 1) begin
            errors++;
            $display("FAIL sc0_done got cyc=%0d n=%0d want 4 1", dc, nd);
        end
        checks++;
        if ({ps2, ec2, fv2} !== {1'b1, 3'd0, 4'b0000}) begin
            errors++;
            $display("FAIL sc0_results got p=%b e=%0d f=%b want 1 0 0000",
                     ps2, ec2, fv2);
        end
        sweep(3, 22, dc, nd);
        checks++;
        if (dc !== 16 || nd !== 1) begin
            errors++;
            $display("FAIL sc3_done got cyc=%0d n=%0d want 16 1", dc, nd);
        end
        checks++;
        if ({ps3, ec3, fv3} !== {1'b1, 3'd0, 4'b0000}) begin
            errors++;
            $display("FAIL sc3_results got p=%b e=%0d f=%b want 1 0 0000",
                     ps3, ec3, fv3);
        end
    endtask

    task automatic test_ignore_start();
        int dc = -1;
        int nd = 0;
        @(posedge clk); #1 st[0] = 1'b1;
        @(posedge clk); #1 st[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 2 || k == 5) st[0] = 1'b1;
            @(posedge clk); #1;
            st[0] = 1'b0;
            if (dn[0]) begin
                nd++;
                if (dc < 0) dc = k;
            end
        end
        checks++;
        if (dc !== 8 || nd !== 1) begin
            errors++;
            $display("FAIL restart_ignored got cyc=%0d n=%0d want 8 1", dc, nd);
        end
        checks++;
        if (bz0 !== 1'b0 || ps0 !== 1'b1) begin
            errors++;
            $display("FAIL restart_idle got busy=%b pass=%b want 0 1", bz0, ps0);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int dc, nd;
        nd = 0;
        @(posedge clk); #1 st[0] = 1'b1;
        @(posedge clk); #1 st[0] = 1'b0;
        repeat (3) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        checks++;
        if ({in0, bz0, dn[0], ps0, ec0, fv0} !== 12'd0) begin
            errors++;
            $display("FAIL midrst_outputs got %h want 0",
                     {in0, bz0, dn[0], ps0, ec0, fv0});
        end
        #3 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (dn[0]) nd++;
        end
        checks++;
        if (nd !== 0 || bz0 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_done got n=%0d busy=%b want 0 0", nd, bz0);
        end
        sweep(0, 12, dc, nd);
        checks++;
        if (dc !== 8 || nd !== 1 || {ps0, ec0, fv0} !== {1'b1, 3'd0, 4'b0000}) begin
            errors++;
            $display("FAIL midrst_resweep got cyc=%0d n=%0d p=%b e=%0d f=%b want 8 1 1 0 0000",
                     dc, nd, ps0, ec0, fv0);
        end
    endtask

    initial begin
        test_reset();
        test_nand_pass();
        test_tied_high();
        test_wrong_expect();
        test_settle_variants();
        test_ignore_start();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
